// File: rtl/uart_rx_fifo.sv
// UART receiver (start/data/optional parity/stop) feeding a first-word-fall-through receive buffer.
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO, otherwise a single holding register.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 16312000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_in,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overrun
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   sync1_q;
    logic                   sync2_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;
    logic                   push_s;
    logic                   pop_s;
    logic                   accept_s;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_in;
            sync2_q <= sync1_q;
        end
    end

    // Frame receiver state machine with registered error pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sync2_q) begin
                        state_q <= START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (!sync2_q) begin
                            state_q   <= DATA;
                            cnt_q     <= CNT_FULL;
                            bit_q     <= '0;
                            par_err_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_q == BIT_LAST) begin
                            state_q <= (PARITY != 32'sd0) ? PAR : STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PAR: begin
                    if (cnt_q == '0) begin
                        // odd parity expects the XOR over data and parity to be 1, even expects 0
                        par_err_q <= (PARITY == 32'sd1) ? ~(^shift_q ^ sync2_q) : (^shift_q ^ sync2_q);
                        cnt_q     <= CNT_FULL;
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == '0) begin
                        if (sync2_q) begin
                            parity_err_q <= par_err_q;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                BREAK: begin
                    if (sync2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign push_s = (state_q == STOP) && (cnt_q == '0) && sync2_q && !par_err_q;

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q;
    logic [AW-1:0]        rd_q;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic                 full_s;

    assign full_s   = (level_q == LW'(FIFO_DEPTH));
    assign pop_s    = (level_q != '0) && i_ready;
    assign accept_s = push_s && (!full_s || pop_s);

    // Occupancy next-state
    always_comb begin
        level_d = level_q;
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage, wrapping pointers and overrun pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            overrun_q <= push_s && full_s && !pop_s;
            level_q   <= level_d;
            if (accept_s) begin
                mem_q[wr_q] <= shift_q;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_s) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_valid = (level_q != '0);
    assign o_level = level_q;
`else
    logic [DATA_BITS-1:0] hold_q;
    logic                 full_q;

    assign pop_s    = full_q && i_ready;
    assign accept_s = push_s && (!full_q || pop_s);

    // Single-entry holding register and overrun pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_q    <= '0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push_s && full_q && !pop_s;
            if (accept_s) begin
                hold_q <= shift_q;
                full_q <= 1'b1;
            end else if (pop_s) begin
                full_q <= 1'b0;
            end else begin
                full_q <= full_q;
            end
        end
    end

    assign o_data  = hold_q;
    assign o_valid = full_q;
    assign o_level = LW'(full_q);
`endif

    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 16312000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate; bit period DIV = CLK_FREQ/BAUD, integer-truncated (default 141).
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries, a power of two and at least 2.
REQ-006 SHALL have port i_clk, input, 1, the single clock.
REQ-007 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have port i_in, input, 1, asynchronous serial line that idles high.
REQ-009 SHALL have port o_data, output, DATA_BITS, head-of-FIFO byte.
REQ-010 SHALL have port o_valid, output, 1, high when the FIFO is non-empty.
REQ-011 SHALL have port i_ready, input, 1, consumer accept.
REQ-012 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-013 SHALL have ports o_frame_err, o_parity_err and o_overrun, each output, 1, a one-cycle event pulse.

Function
REQ-014 SHALL pass i_in through a 2-FF synchroniser before any use.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PAR, STOP and BREAK.
- IDLE: low on the synchronised line -> START, counter loaded DIV/2-1.
REQ-016 In START, at counter expiry (mid start bit), SHALL go to DATA with counter loaded DIV-1 if the line is low; if high, SHALL return to IDLE with no error (glitch reject).
REQ-017 In DATA, SHALL sample one bit every DIV cycles, LSB first, shifting in DATA_BITS bits, then go to PAR if PARITY!=0, else STOP.
REQ-018 In PAR, SHALL sample one bit and flag a parity error if the XOR of data and parity bit is 0 for odd parity, or 1 for even parity.
REQ-019 In STOP, at the mid-stop sample:
- line high with no parity error: push byte, go to IDLE immediately.
- line high with parity error: discard byte, pulse o_parity_err.
- line low: discard byte, pulse o_frame_err, go to BREAK.
REQ-020 In BREAK, SHALL go to IDLE once the line is seen high.
REQ-021 SHALL present o_data/o_valid exactly 1 cycle after the stop-sample cycle for an accepted byte.
REQ-022 The FIFO SHALL be first-word-fall-through; pop occurs when o_valid && i_ready.
REQ-023 SHALL accept a push when not full, or when full with a pop in the same cycle (o_level unchanged).
REQ-024 A push while full with no pop SHALL drop the byte, pulse o_overrun and leave FIFO contents intact.
REQ-025 Simultaneous push and pop on an empty FIFO SHALL NOT be possible, because the first-word-fall-through head is not valid until the cycle after the push.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; o_level SHALL reach FIFO_DEPTH exactly when full.

Reset
REQ-027 i_rst SHALL asynchronously force:
- FSM to IDLE;
- synchroniser flops to 1;
- FIFO empty (o_level=0, o_valid=0);
- o_data to 0;
- all error pulses to 0.
REQ-028 Reset mid-frame SHALL discard the partial byte; the first falling edge after release SHALL start a clean frame.

Configuration
REQ-029 With macro UART_RX_FIFO_EN defined, the FIFO SHALL have FIFO_DEPTH entries as specified above.
REQ-030 Without UART_RX_FIFO_EN, storage SHALL be a single holding register:
- o_level takes only values 0/1 at unchanged width;
- a push while the register is occupied and not popped pulses o_overrun;
- all other behaviour is identical.

Verification (CLK_FREQ=16312000, BAUD=115200, DIV=141, UART_RX_FIFO_EN defined unless noted)
REQ-031 Send 0x55 as 8N1 -> o_data=0x55, o_valid=1 exactly 1 cycle after the stop sample, o_level=1; i_ready=1 -> o_level=0 next cycle.
REQ-032 Drive i_in low for 40 cycles, then high -> no o_valid, no error pulses, FSM back in IDLE.
REQ-033 Send 0xA3 with stop bit low for 2 bit times -> one o_frame_err pulse, o_level stays 0, next 0x3C received correctly.
REQ-034 With PARITY=2, send 0x07 with parity bit 0 -> one o_parity_err pulse, nothing pushed; with parity bit 1 -> 0x07 received.
REQ-035 Hold i_ready=0 and send 0x00..0x10 (17 bytes) -> o_level=16, one o_overrun on the 17th; drain yields 0x00..0x0F in order. Without UART_RX_FIFO_EN -> o_level=1 and 0x00 retained.
REQ-036 Assert i_rst during data bit 3 of a frame, release, then send 0x3C -> o_valid=0 and o_level=0 during reset; 0x3C received alone afterwards.
